// File: rtl/next_hop_select_update_if.sv
// Shared node-memory bus: word address, write strobe/data, read data one cycle after address.
interface next_hop_select_update_if;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic [15:0] data_in;

  modport master (output address, output wr_en, output data_out, input data_in);
  modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/next_hop_select_update.sv
// Picks the forwarding neighbour (sink beats best-Q), updates this node's own Q value
// and writes the new Q and the chosen next-hop ID back to node memory.
module next_hop_select_update #(
  parameter logic [15:0] NO_HOP       = 16'd65,
  parameter int unsigned ALPHA_SHIFT  = 2,
  parameter logic [15:0] NBR_ID_BASE  = 16'h0048,
  parameter logic [15:0] MYQ_ADDR     = 16'h068E,
  parameter logic [15:0] NEXTHOP_ADDR = 16'h0690,
  parameter logic [15:0] QMAX         = 16'hFFFE
) (
  input  logic                               clock,
  input  logic                               rst,
  input  logic                               start,
  input  logic [15:0]                        besthop,
  input  logic [15:0]                        bestvalue,
  input  logic [15:0]                        bestneighborID,
  input  logic [15:0]                        nextsinks,
  input  logic [15:0]                        link_cost,
  next_hop_select_update_if.master           bus,
  output logic [15:0]                        next_hop_id,
  output logic                               route_valid,
  output logic                               to_sink,
  output logic [15:0]                        myq_new,
  output logic                               done
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = DW + 2;
  localparam int unsigned FW = DW + 3;

  typedef enum logic [3:0] {
    IDLE, RDQ, LATQ, RDSINK, LATSINK, CALC, WRQ, WRHOP, WREND, DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] besthop_q;
  logic [DW-1:0] bestvalue_q;
  logic [DW-1:0] bestid_q;
  logic [DW-1:0] nextsinks_q;
  logic [DW-1:0] link_cost_q;
  logic [DW-1:0] old_q;

  logic [TW-1:0]        target_c;
  logic signed [FW-1:0] diff_c;
  logic signed [FW-1:0] step_c;
  logic signed [FW:0]   sum_c;
  logic [DW-1:0]        q_new_c;

  // Q update: old + (target - old) * 2^-ALPHA_SHIFT, clamped to [0, QMAX]
  always_comb begin
    target_c = TW'(link_cost_q) + (to_sink ? TW'(0) : TW'(bestvalue_q));
    diff_c   = signed'(FW'(target_c) - FW'(old_q));
    step_c   = diff_c >>> ALPHA_SHIFT;
    sum_c    = signed'({4'b0, old_q}) + signed'({step_c[FW-1], step_c});
    q_new_c  = sum_c[DW-1:0];
    if (sum_c[FW]) begin
      q_new_c = '0;
    end else if (sum_c[FW-1:0] > FW'(QMAX)) begin
      q_new_c = QMAX;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= IDLE;
      bus.address  <= MYQ_ADDR;
      bus.wr_en    <= 1'b0;
      bus.data_out <= '0;
      next_hop_id  <= '0;
      route_valid  <= 1'b0;
      to_sink      <= 1'b0;
      myq_new      <= QMAX;
      done         <= 1'b0;
      besthop_q    <= NO_HOP;
      bestvalue_q  <= '0;
      bestid_q     <= '0;
      nextsinks_q  <= NO_HOP;
      link_cost_q  <= '0;
      old_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            besthop_q   <= besthop;
            bestvalue_q <= bestvalue;
            bestid_q    <= bestneighborID;
            nextsinks_q <= nextsinks;
            link_cost_q <= link_cost;
            bus.address <= MYQ_ADDR;
            done        <= 1'b0;
            route_valid <= 1'b0;
            to_sink     <= 1'b0;
            state       <= RDQ;
          end
        end
        RDQ: state <= LATQ;
        LATQ: begin
          old_q <= bus.data_in;
          // a known sink neighbour wins over the best-Q neighbour
          if (nextsinks_q != NO_HOP) begin
            bus.address <= NBR_ID_BASE + (nextsinks_q << 1);
            to_sink     <= 1'b1;
            state       <= RDSINK;
          end else if (besthop_q != NO_HOP) begin
            next_hop_id <= bestid_q;
            state       <= CALC;
          end else begin
            route_valid <= 1'b0;
            state       <= DONE;
          end
        end
        RDSINK: state <= LATSINK;
        LATSINK: begin
          next_hop_id <= bus.data_in;
          state       <= CALC;
        end
        CALC: begin
          myq_new     <= q_new_c;
          route_valid <= 1'b1;
          state       <= WRQ;
        end
        WRQ: begin
          bus.address  <= MYQ_ADDR;
          bus.data_out <= myq_new;
          bus.wr_en    <= 1'b1;
          state        <= WRHOP;
        end
        WRHOP: begin
          bus.address  <= NEXTHOP_ADDR;
          bus.data_out <= next_hop_id;
          bus.wr_en    <= 1'b1;
          state        <= WREND;
        end
        WREND: begin
          bus.wr_en <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          // done is raised on the first DONE cycle, then held until start drops
          if (done && !start) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
